// File: rtl/data_path_if.sv
// Control-strobe and I/O bundle between the Mini SRC control unit (master) and
// the data_path block (slave).
interface data_path_if;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, INPort_In, Cout, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutPortIn;
  logic        Gra, Grb, Grc;
  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;
  logic        Read, Write, Strobe;
  logic [31:0] InPort_Data;
  logic [31:0] OutPort_Out;
  logic        BranchOut;

  modport master (
    output PCout, Zlowout, Zhighout, MDRout, HIout, LOout, INPort_In, Cout, Rout, BAout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutPortIn,
    output Gra, Grb, Grc,
    output IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
    output Read, Write, Strobe, InPort_Data,
    input  OutPort_Out, BranchOut
  );

  modport slave (
    input  PCout, Zlowout, Zhighout, MDRout, HIout, LOout, INPort_In, Cout, Rout, BAout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, Rin, CONin, OutPortIn,
    input  Gra, Grb, Grc,
    input  IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT,
    input  Read, Write, Strobe, InPort_Data,
    output OutPort_Out, BranchOut
  );
endinterface

// File: rtl/data_path.sv
// Mini SRC single-bus datapath: registers, ALU, RAM, IR select logic, CON flip-flop, I/O ports.
module data_path #(
  parameter int MEM_AW = 9
) (
  input logic        Clock,
  input logic        Clear,
  data_path_if.slave io
);

  logic [31:0] pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q, in_q, out_q;
  logic [63:0] z_q;
  logic        con_q;
  logic [31:0] r_q [16];
  logic [31:0] mem [2**MEM_AW];

  initial begin
    for (int i = 0; i < 2**MEM_AW; i++) mem[i] = '0;
  end

  logic [3:0]  sel;
  logic [31:0] c_ext, bus;
  logic [MEM_AW-1:0] addr;
  logic        unused_bits;

  assign sel   = ({4{io.Gra}} & ir_q[26:23]) | ({4{io.Grb}} & ir_q[22:19]) | ({4{io.Grc}} & ir_q[18:15]);
  assign c_ext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign addr  = mar_q[MEM_AW-1:0];
  assign unused_bits = ^{ir_q[31:27], mar_q[31:MEM_AW]};

  always_comb begin
    bus = '0;
    if (io.PCout)          bus = pc_q;
    else if (io.Zlowout)   bus = z_q[31:0];
    else if (io.Zhighout)  bus = z_q[63:32];
    else if (io.MDRout)    bus = mdr_q;
    else if (io.HIout)     bus = hi_q;
    else if (io.LOout)     bus = lo_q;
    else if (io.INPort_In) bus = in_q;
    else if (io.Cout)      bus = c_ext;
    else if (io.Rout)      bus = r_q[sel];
    else if (io.BAout)     bus = (sel == 4'd0) ? 32'd0 : r_q[sel];
  end

  // ALU operands: A is always Y, B is the bus.
  logic [4:0]         sh;
  logic [63:0]        ror_w, rol_w;
  logic [31:0]        sra_w;
  logic signed [63:0] ys, bs, prod;
  logic signed [31:0] quo, rem;
  logic [63:0]        alu;

  assign sh    = bus[4:0];
  assign ror_w = {y_q, y_q} >> sh;
  assign rol_w = {y_q, y_q} << sh;
  assign sra_w = $signed(y_q) >>> sh;
  assign ys    = {{32{y_q[31]}}, y_q};
  assign bs    = {{32{bus[31]}}, bus};
  assign prod  = ys * bs;
  assign quo   = (bus == 32'd0) ? 32'sd0 : $signed(y_q) / $signed(bus);
  assign rem   = (bus == 32'd0) ? 32'sd0 : $signed(y_q) % $signed(bus);

  always_comb begin
    alu = {32'd0, bus};
    if (io.IncPC)     alu = {32'd0, bus + 32'd1};
    else if (io.ADD)  alu = {32'd0, y_q + bus};
    else if (io.SUB)  alu = {32'd0, y_q - bus};
    else if (io.AND)  alu = {32'd0, y_q & bus};
    else if (io.OR)   alu = {32'd0, y_q | bus};
    else if (io.SHR)  alu = {32'd0, y_q >> sh};
    else if (io.SHRA) alu = {32'd0, sra_w};
    else if (io.SHL)  alu = {32'd0, y_q << sh};
    else if (io.ROR)  alu = {32'd0, ror_w[31:0]};
    else if (io.ROL)  alu = {32'd0, rol_w[63:32]};
    else if (io.MUL)  alu = prod;
    else if (io.DIV)  alu = {rem, quo};
    else if (io.NEG)  alu = {32'd0, 32'd0 - bus};
    else if (io.NOT)  alu = {32'd0, ~bus};
  end

  logic con_cond;
  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_cond = (bus == 32'd0);
      2'b01:   con_cond = (bus != 32'd0);
      2'b10:   con_cond = ~bus[31];
      default: con_cond = bus[31];
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      in_q  <= '0;
      out_q <= '0;
      con_q <= 1'b0;
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
    end else begin
      if (io.PCin)      pc_q  <= bus;
      if (io.IRin)      ir_q  <= bus;
      if (io.MARin)     mar_q <= bus;
      if (io.MDRin)     mdr_q <= io.Read ? mem[addr] : bus;
      if (io.Yin)       y_q   <= bus;
      if (io.Zin)       z_q   <= alu;
      if (io.HIin)      hi_q  <= bus;
      if (io.LOin)      lo_q  <= bus;
      if (io.Rin)       r_q[sel] <= bus;
      if (io.CONin)     con_q <= con_cond;
      if (io.Strobe)    in_q  <= io.InPort_Data;
      if (io.OutPortIn) out_q <= bus;
    end
  end

  // RAM takes the pre-edge MDR, so Write with MDRin stores the old value.
  always @(posedge Clock) begin
    if (Clear && io.Write) mem[addr] <= mdr_q;
  end

  assign io.OutPort_Out = out_q;
  assign io.BranchOut   = con_q;

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: fetch, load, ALU, CON, I/O and mid-operation reset.
module tb_data_path;

  logic Clock = 1'b0;
  logic Clear = 1'b0;
  int   total = 0;
  int   bad   = 0;

  data_path_if io();
  data_path dut (.Clock(Clock), .Clear(Clear), .io(io));

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {io.PCout, io.Zlowout, io.Zhighout, io.MDRout, io.HIout, io.LOout, io.INPort_In, io.Cout, io.Rout, io.BAout} = '0;
    {io.PCin, io.IRin, io.MARin, io.MDRin, io.Yin, io.Zin, io.HIin, io.LOin, io.Rin, io.CONin, io.OutPortIn} = '0;
    {io.Gra, io.Grb, io.Grc} = '0;
    {io.IncPC, io.ADD, io.SUB, io.AND, io.OR, io.SHR, io.SHRA, io.SHL, io.ROR, io.ROL, io.MUL, io.DIV, io.NEG, io.NOT} = '0;
    {io.Read, io.Write, io.Strobe} = '0;
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic inport(input logic [31:0] v);
    io.InPort_Data = v; io.Strobe = 1'b1; cycle();
  endtask

  task automatic set_ir(input logic [31:0] v);
    inport(v); io.INPort_In = 1'b1; io.IRin = 1'b1; cycle();
  endtask

  task automatic load_gpr(input logic [3:0] idx, input logic [31:0] v);
    set_ir({5'd0, idx, 23'd0});
    inport(v); io.INPort_In = 1'b1; io.Gra = 1'b1; io.Rin = 1'b1; cycle();
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d);
    inport(a); io.INPort_In = 1'b1; io.MARin = 1'b1; cycle();
    inport(d); io.INPort_In = 1'b1; io.MDRin = 1'b1; cycle();
    io.Write = 1'b1; cycle();
  endtask

  task automatic set_y(input logic [31:0] v);
    inport(v); io.INPort_In = 1'b1; io.Yin = 1'b1; cycle();
  endtask

  task automatic show_ra(input string tag, input logic [31:0] exp);
    io.Gra = 1'b1; io.Rout = 1'b1; io.OutPortIn = 1'b1; cycle();
    check(tag, {32'd0, io.OutPort_Out}, {32'd0, exp});
  endtask

  task automatic run_load(input logic [31:0] ir);
    set_ir(ir);
    io.Grb = 1'b1; io.BAout = 1'b1; io.Yin = 1'b1; cycle();
    io.Cout = 1'b1; io.ADD = 1'b1; io.Zin = 1'b1; cycle();
    io.Zlowout = 1'b1; io.MARin = 1'b1; cycle();
    io.Read = 1'b1; io.MDRin = 1'b1; cycle();
    io.MDRout = 1'b1; io.Gra = 1'b1; io.Rin = 1'b1; cycle();
  endtask

  task automatic con_test(input string tag, input logic [1:0] c2, input logic [31:0] v, input logic exp);
    set_ir({11'd0, c2, 19'd0});
    inport(v); io.INPort_In = 1'b1; io.CONin = 1'b1; cycle();
    check(tag, {63'd0, io.BranchOut}, {63'd0, exp});
  endtask

  initial begin
    idle();
    io.InPort_Data = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_out", {32'd0, io.OutPort_Out}, 64'd0);
    check("rst_br", {63'd0, io.BranchOut}, 64'd0);
    check("rst_pc", {32'd0, dut.pc_q}, 64'd0);
    Clear = 1'b1;

    // Fetch
    mem_write(32'd0, 32'h0088_0000);
    io.PCout = 1'b1; io.MARin = 1'b1; io.IncPC = 1'b1; io.Zin = 1'b1; cycle();
    check("fetch_mar", {32'd0, dut.mar_q}, 64'd0);
    check("fetch_z", dut.z_q, 64'd1);
    io.Zlowout = 1'b1; io.PCin = 1'b1; io.Read = 1'b1; io.MDRin = 1'b1; cycle();
    check("fetch_pc", {32'd0, dut.pc_q}, 64'd1);
    io.MDRout = 1'b1; io.IRin = 1'b1; cycle();
    check("fetch_ir", {32'd0, dut.ir_q}, 64'h0088_0000);

    // ld R1,0x54(R2)
    load_gpr(4'd2, 32'h10);
    mem_write(32'h64, 32'h1234);
    run_load(32'h0090_0054);
    check("ld_mar", {32'd0, dut.mar_q}, 64'h64);
    show_ra("ld_r1", 32'h1234);

    // ld R1,0x54(R0): base reads as 0 even with R0 loaded
    load_gpr(4'd0, 32'h777);
    mem_write(32'h54, 32'hBEEF);
    run_load(32'h0080_0054);
    check("ld0_mar", {32'd0, dut.mar_q}, 64'h54);
    show_ra("ld0_r1", 32'hBEEF);

    // ALU
    set_y(32'hFFFF_FFFE);
    inport(32'd3); io.INPort_In = 1'b1; io.MUL = 1'b1; io.Zin = 1'b1; cycle();
    check("mul", dut.z_q, 64'hFFFF_FFFF_FFFF_FFFA);
    io.Zhighout = 1'b1; io.HIin = 1'b1; cycle();
    io.HIout = 1'b1; io.OutPortIn = 1'b1; cycle();
    check("hi_out", {32'd0, io.OutPort_Out}, 64'hFFFF_FFFF);
    set_y(32'd7);
    inport(32'hFFFF_FFFE); io.INPort_In = 1'b1; io.DIV = 1'b1; io.Zin = 1'b1; cycle();
    check("div", dut.z_q, 64'h0000_0001_FFFF_FFFD);
    inport(32'd0); io.INPort_In = 1'b1; io.DIV = 1'b1; io.Zin = 1'b1; cycle();
    check("div0", dut.z_q, 64'd0);
    set_y(32'd5);
    inport(32'd7); io.INPort_In = 1'b1; io.SUB = 1'b1; io.Zin = 1'b1; cycle();
    check("sub", dut.z_q, 64'h0000_0000_FFFF_FFFE);
    set_y(32'h8000_0000);
    inport(32'd4); io.INPort_In = 1'b1; io.SHRA = 1'b1; io.Zin = 1'b1; cycle();
    check("shra", dut.z_q, 64'hF800_0000);
    set_y(32'h8000_0001);
    inport(32'd4); io.INPort_In = 1'b1; io.ROL = 1'b1; io.Zin = 1'b1; cycle();
    check("rol", dut.z_q, 64'h18);
    set_y(32'h1);
    inport(32'd1); io.INPort_In = 1'b1; io.ROR = 1'b1; io.Zin = 1'b1; cycle();
    check("ror", dut.z_q, 64'h8000_0000);
    inport(32'd9); io.INPort_In = 1'b1; io.NEG = 1'b1; io.Zin = 1'b1; cycle();
    check("neg", dut.z_q, 64'hFFFF_FFF7);

    // Sign-extended constant
    set_ir(32'h0004_0000);
    io.Cout = 1'b1; io.OutPortIn = 1'b1; cycle();
    check("cout_sx", {32'd0, io.OutPort_Out}, 64'hFFFC_0000);

    // Write with MDRin stores the old MDR
    mem_write(32'h20, 32'h11);
    inport(32'h22); io.INPort_In = 1'b1; io.MDRin = 1'b1; io.Write = 1'b1; cycle();
    io.Read = 1'b1; io.MDRin = 1'b1; cycle();
    io.MDRout = 1'b1; io.OutPortIn = 1'b1; cycle();
    check("wr_old_mdr", {32'd0, io.OutPort_Out}, 64'h11);

    // CON
    con_test("con_eq0", 2'b00, 32'd0, 1'b1);
    con_test("con_neg", 2'b11, 32'h8000_0000, 1'b1);
    con_test("con_pos", 2'b10, 32'h8000_0000, 1'b0);
    con_test("con_ne0", 2'b01, 32'd5, 1'b1);

    // I/O
    set_ir(32'h0180_0000);
    inport(32'hA5); io.INPort_In = 1'b1; io.Gra = 1'b1; io.Rin = 1'b1; cycle();
    show_ra("io_out", 32'hA5);

    // Reset mid-instruction
    io.PCout = 1'b1; io.MARin = 1'b1; io.IncPC = 1'b1; io.Zin = 1'b1;
    #2;
    Clear = 1'b0;
    #1;
    check("mid_pc", {32'd0, dut.pc_q}, 64'd0);
    check("mid_ir", {32'd0, dut.ir_q}, 64'd0);
    check("mid_r3", {32'd0, dut.r_q[3]}, 64'd0);
    check("mid_z", dut.z_q, 64'd0);
    check("mid_out", {32'd0, io.OutPort_Out}, 64'd0);
    check("mid_br", {63'd0, io.BranchOut}, 64'd0);
    idle();
    io.InPort_Data = 32'h55; io.Strobe = 1'b1; io.INPort_In = 1'b1; io.OutPortIn = 1'b1; io.Zin = 1'b1;
    @(posedge Clock);
    #1;
    check("hold_out", {32'd0, io.OutPort_Out}, 64'd0);
    check("hold_in", {32'd0, dut.in_q}, 64'd0);
    idle();
    Clear = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
